data_memory_lsu: RTL and testbench

Parametrised, handshaked data memory for the RISC-V core. It executes RV32I sized loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes and sign/zero-extended reads, and flags misaligned and out-of-range accesses. A configurable fixed access latency lets the core's load/store stage be exercised against a slow memory. It sits between the execute/memory stage and word-organised storage, with one outstanding request at a time.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_load_align.sv | 40 ++++
 rtl/data_memory_lsu.sv | 168 ++++++++++++++++
 tb/tb_data_memory_lsu.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and counter sizing for the data memory LSU.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // Latency counter must hold the value LATENCY itself.
    function automatic int cnt_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half/word out of a storage word and sign- or zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        w_sign = 1'b0;
        o_data = i_word;
        case (i_size)
            SIZE_B: begin
                w_sign = ~i_unsigned & w_byte[7];
                o_data = {{24{w_sign}}, w_byte};
            end
            SIZE_H: begin
                w_sign = ~i_unsigned & w_half[15];
                o_data = {{16{w_sign}}, w_half};
            end
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// Handshaked word-organised data memory executing RV32I sized loads/stores with a
// fixed response latency and one outstanding request.
//
// state | meaning
// IDLE  | ready for a request; acceptance latches response and commits stores
// WAIT  | burning the remaining LATENCY-1 cycles
// RESP  | rsp_valid pulse, then back to IDLE
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(LATENCY);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_pend_rdata;
    logic               r_pend_err;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic [31:0]        r_mem [DEPTH];

    logic               w_accept;
    logic [IDX_W-1:0]   w_idx;
    logic               w_oor;
    logic               w_misalign;
    logic               w_bad_size;
    logic               w_err;
    logic [3:0]         w_be;
    logic [31:0]        w_wlanes;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_load_data;
    logic [31:0]        w_rdata;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_idx     = req_addr[IDX_W+1:2];

    // Any word-index bit above the storage depth puts the access out of range.
    generate
        if (ADDR_W - 2 > IDX_W) begin : g_oor
            assign w_oor = |req_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_misalign = ((req_size == SIZE_H) && req_addr[0]) ||
                        ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
    assign w_bad_size = (req_size == 2'b11);
    assign w_err      = w_oor || w_misalign || w_bad_size;

    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = req_wdata;
        case (req_size)
            SIZE_B: begin
                w_be     = 4'b0001 << req_addr[1:0];
                w_wlanes = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
                w_be     = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{req_wdata[15:0]}};
            end
            SIZE_W: begin
                w_be     = 4'b1111;
                w_wlanes = req_wdata;
            end
            default: w_be = 4'b0000;
        endcase
    end

    assign w_rd_word = r_mem[w_idx];

    dmem_load_align u_load_align (
        .i_word     (w_rd_word),
        .i_off      (req_addr[1:0]),
        .i_size     (req_size),
        .i_unsigned (req_unsigned),
        .o_data     (w_load_data)
    );

    assign w_rdata = (req_we || w_err) ? 32'h0 : w_load_data;

    // Storage is deliberately not reset; only legal accepted stores touch it.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_pend_rdata <= 32'h0;
            r_pend_err   <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 32'h0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (w_accept) begin
                        r_pend_rdata <= w_rdata;
                        r_pend_err   <= w_err;
                        if (LATENCY == 1) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rdata;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= RESP;
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pend_rdata;
                        r_rsp_err   <= r_pend_err;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: one LATENCY=1 and one LATENCY=3 instance.
module tb_data_memory_lsu;
    import dmem_pkg::*;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][1:0]  req_size;
    logic [1:0]       req_unsigned;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_valid;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    data_memory_lsu #(.ADDR_W(32), .DEPTH(1024), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    data_memory_lsu #(.ADDR_W(32), .DEPTH(1024), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one request on instance d, push its expectation, wait (bounded) for the response.
    task automatic op(input int d, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err,
                      output logic [31:0] got_rd, output logic got_err, output int lat);
        bit seen;
        int acc;
        seen = 0;
        acc  = -1000;
        lat  = -1;
        got_rd  = 32'hxxxx_xxxx;
        got_err = 1'bx;
        req_we[d] = we; req_size[d] = sz; req_unsigned[d] = uns;
        req_addr[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[d]) begin seen = 1; break; end
        end
        if (seen) begin
            @(posedge clk); #1;
            acc = cyc;
        end
        req_valid[d] = 1'b0;
        sb.push_back('{exp_rd, exp_err, acc});
        if (seen) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rsp_valid[d]) begin
                    got_rd  = rsp_rdata[d];
                    got_err = rsp_err[d];
                    lat     = cyc - acc + 1;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (req_ready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst d%0d got %b exp 0", d, req_ready[d]); end
            n_tests++;
            if ({rsp_valid[d], rsp_err[d], rsp_rdata[d]} !== 34'h0)
                begin n_fail++; $display("FAIL reset_outputs d%0d got v=%b e=%b rd=%h exp all 0", d, rsp_valid[d], rsp_err[d], rsp_rdata[d]); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (req_ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after d%0d got %b exp 1", d, req_ready[d]); end
        end
    endtask

    task automatic test_word_rw();
        vec_t t[2];
        logic [31:0] rd; logic er; int lat; exp_t e;
        t[0] = '{1'b1, SIZE_W, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0};
        t[1] = '{1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0};
        for (int i = 0; i < 2; i++) begin
            op(0, t[i].we, t[i].sz, t[i].uns, t[i].addr, t[i].wd, t[i].rd, t[i].err, rd, er, lat);
            e = sb.pop_front();
            n_tests++;
            if (rd !== e.rdata) begin n_fail++; $display("FAIL word_rw[%0d] rdata got %h exp %h", i, rd, e.rdata); end
            n_tests++;
            if (er !== e.err) begin n_fail++; $display("FAIL word_rw[%0d] err got %b exp %b", i, er, e.err); end
            n_tests++;
            if (lat != 1) begin n_fail++; $display("FAIL word_rw[%0d] latency got %0d exp 1", i, lat); end
        end
    endtask

    task automatic test_sub_word();
        vec_t t[5];
        logic [31:0] rd; logic er; int lat; exp_t e;
        t[0] = '{1'b1, SIZE_B, 1'b0, 32'h101, 32'h00000080, 32'h0,        1'b0};
        t[1] = '{1'b0, SIZE_W, 1'b0, 32'h100, 32'h0,        32'hDEAD80EF, 1'b0};
        t[2] = '{1'b0, SIZE_B, 1'b0, 32'h101, 32'h0,        32'hFFFFFF80, 1'b0};
        t[3] = '{1'b0, SIZE_B, 1'b1, 32'h101, 32'h0,        32'h00000080, 1'b0};
        t[4] = '{1'b0, SIZE_H, 1'b1, 32'h102, 32'h0,        32'h0000DEAD, 1'b0};
        for (int i = 0; i < 5; i++) begin
            op(0, t[i].we, t[i].sz, t[i].uns, t[i].addr, t[i].wd, t[i].rd, t[i].err, rd, er, lat);
            e = sb.pop_front();
            n_tests++;
            if (rd !== e.rdata) begin n_fail++; $display("FAIL sub_word[%0d] rdata got %h exp %h", i, rd, e.rdata); end
            n_tests++;
            if (er !== e.err) begin n_fail++; $display("FAIL sub_word[%0d] err got %b exp %b", i, er, e.err); end
            n_tests++;
            if (lat != 1) begin n_fail++; $display("FAIL sub_word[%0d] latency got %0d exp 1", i, lat); end
        end
    endtask

    task automatic test_errors();
        vec_t t[10];
        logic [31:0] rd; logic er; int lat; exp_t e;
        t[0] = '{1'b1, SIZE_H, 1'b0, 32'h103,  32'h00001234, 32'h0,        1'b1};
        t[1] = '{1'b0, SIZE_W, 1'b0, 32'h100,  32'h0,        32'hDEAD80EF, 1'b0};
        t[2] = '{1'b0, SIZE_W, 1'b0, 32'h102,  32'h0,        32'h0,        1'b1};
        t[3] = '{1'b0, SIZE_W, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1};
        t[4] = '{1'b1, 2'b11,  1'b0, 32'h100,  32'hFFFFFFFF, 32'h0,        1'b1};
        t[5] = '{1'b0, SIZE_W, 1'b0, 32'h100,  32'h0,        32'hDEAD80EF, 1'b0};
        t[6] = '{1'b0, SIZE_H, 1'b0, 32'h102,  32'h0,        32'hFFFFDEAD, 1'b0};
        t[7] = '{1'b1, SIZE_W, 1'b0, 32'h0,    32'h00000055, 32'h0,        1'b0};
        t[8] = '{1'b1, SIZE_W, 1'b0, 32'h1000, 32'hFFFFFFFF, 32'h0,        1'b1};
        t[9] = '{1'b0, SIZE_W, 1'b0, 32'h0,    32'h0,        32'h00000055, 1'b0};
        for (int i = 0; i < 10; i++) begin
            op(0, t[i].we, t[i].sz, t[i].uns, t[i].addr, t[i].wd, t[i].rd, t[i].err, rd, er, lat);
            e = sb.pop_front();
            n_tests++;
            if (rd !== e.rdata) begin n_fail++; $display("FAIL errors[%0d] rdata got %h exp %h", i, rd, e.rdata); end
            n_tests++;
            if (er !== e.err) begin n_fail++; $display("FAIL errors[%0d] err got %b exp %b", i, er, e.err); end
            n_tests++;
            if (lat != 1) begin n_fail++; $display("FAIL errors[%0d] latency got %0d exp 1", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; exp_t e;
        int last_acc; int n_acc;
        op(1, 1'b1, SIZE_W, 1'b0, 32'h0, 32'h11223344, 32'h0, 1'b0, rd, er, lat);
        e = sb.pop_front();
        n_tests++;
        if (er !== e.err || rd !== e.rdata) begin n_fail++; $display("FAIL b2b_store got rd=%h err=%b exp rd=%h err=%b", rd, er, e.rdata, e.err); end
        n_tests++;
        if (lat != 3) begin n_fail++; $display("FAIL b2b_store latency got %0d exp 3", lat); end

        last_acc = -1; n_acc = 0;
        req_we[1] = 1'b0; req_size[1] = SIZE_W; req_unsigned[1] = 1'b0;
        req_addr[1] = 32'h0; req_wdata[1] = 32'h0; req_valid[1] = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) begin
                n_tests++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_unexpected_rsp got rsp_valid=1 exp 0 at cycle %0d", cyc); end
                else begin
                    e = sb.pop_front();
                    if (rsp_rdata[1] !== e.rdata) begin n_fail++; $display("FAIL b2b_rdata got %h exp %h", rsp_rdata[1], e.rdata); end
                    n_tests++;
                    if (cyc - e.acc + 1 != 3) begin n_fail++; $display("FAIL b2b_latency got %0d exp 3", cyc - e.acc + 1); end
                end
            end
            if (req_ready[1]) begin
                if (last_acc >= 0) begin
                    n_tests++;
                    if (cyc + 1 - last_acc != 4) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 4", cyc + 1 - last_acc); end
                end
                last_acc = cyc + 1;
                n_acc++;
                sb.push_back('{32'h11223344, 1'b0, cyc + 1});
            end
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            if (rsp_valid[1]) begin
                e = sb.pop_front();
                n_tests++;
                if (rsp_rdata[1] !== e.rdata || cyc - e.acc + 1 != 3)
                    begin n_fail++; $display("FAIL b2b_drain got rd=%h lat=%0d exp rd=%h lat=3", rsp_rdata[1], cyc - e.acc + 1, e.rdata); end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_missing_rsp got %0d pending exp 0", sb.size()); sb.delete(); end
        n_tests++;
        if (n_acc < 4) begin n_fail++; $display("FAIL b2b_accept_count got %0d exp >=4", n_acc); end
    endtask

    task automatic test_reset_pending();
        logic [31:0] rd; logic er; int lat; exp_t e;
        bit seen; int n_rsp;
        seen = 0; n_rsp = 0;
        req_we[1] = 1'b1; req_size[1] = SIZE_W; req_unsigned[1] = 1'b0;
        req_addr[1] = 32'h8; req_wdata[1] = 32'hCAFEF00D; req_valid[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[1]) begin seen = 1; break; end
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL rstp_accept got no acceptance exp accepted"); end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL rstp_ready_in_rst got %b exp 0", req_ready[1]); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL rstp_ready_after got %b exp 1", req_ready[1]); end
        n_tests++;
        if (rsp_rdata[1] !== 32'h0 || rsp_err[1] !== 1'b0)
            begin n_fail++; $display("FAIL rstp_outputs got rd=%h err=%b exp 0", rsp_rdata[1], rsp_err[1]); end
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid[1]) n_rsp++;
            @(negedge clk);
        end
        n_tests++;
        if (n_rsp != 0) begin n_fail++; $display("FAIL rstp_dropped_rsp got %0d pulses exp 0", n_rsp); end
        op(1, 1'b0, SIZE_W, 1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, rd, er, lat);
        e = sb.pop_front();
        n_tests++;
        if (rd !== e.rdata || er !== e.err)
            begin n_fail++; $display("FAIL rstp_store_kept got rd=%h err=%b exp rd=%h err=%b", rd, er, e.rdata, e.err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_size = '0; req_unsigned = '0;
        req_addr = '0; req_wdata = '0;
        test_reset();
        test_word_rw();
        test_sub_word();
        test_errors();
        test_back_to_back();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
